uart_tx_port: RTL and testbench

- Write-side UART transmitter peripheral that sits directly downstream of the port address decoder.
- One decoded write-strobe bit pushes the processor's output byte into a small FIFO.
- An internal baud generator and a shift FSM serialise each byte as 8N1 on the tx pin.
- A status byte is returned for the read-side input mux (paired with a decoded read-strobe bit).

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_fifo.sv | 77 +++++++
 rtl/uart_tx_port.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_port.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit port.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  localparam int OVF_BIT   = 3;
  localparam int BUSY_BIT  = 2;
  localparam int FULL_BIT  = 1;
  localparam int EMPTY_BIT = 0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Even parity of a data byte (XOR of all bits).
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO buffering bytes ahead of the UART shifter.
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty = (count_q == CW'(0));
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Next pointers, count and storage; full/empty are the pre-edge flags.
  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is defined by the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_tx_port.sv
// UART 8N1 transmit port: TX FIFO, baud counter, shift FSM and status byte.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_port
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 868,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] din,
  input  logic       ovf_clr,
  output logic       tx,
  output logic [7:0] status
);

  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  tx_state_e                 state_q, state_d;
  logic [15:0]               baud_q, baud_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic                      tx_q, tx_d;
  logic                      ovf_q, ovf_d;
  logic                      fifo_pop, fifo_empty, fifo_full;
  logic [UART_DATA_BITS-1:0] fifo_dout;
  logic [CW-1:0]             fifo_count;
  logic                      bit_end, have_data;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q, parity_d;
`endif

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_en),
    .pop   (fifo_pop),
    .din   (din),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign bit_end   = (baud_q == BAUD_LAST);
  assign have_data = (fifo_count != CW'(0));
  assign tx        = tx_q;

  // Frame sequencing: baud counter, bit index, shifter and FIFO pops.
  always_comb begin
    state_d   = state_q;
    baud_d    = bit_end ? 16'd0 : baud_q + 16'd1;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d    = 16'd0;
        bit_idx_d = 3'd0;
        if (have_data) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_dout;
          state_d  = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
        else         state_d = START;
      end
      DATA: begin
        if (bit_end) begin
          shreg_d   = {1'b0, shreg_q[UART_DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
`ifdef UART_TX_PARITY_EN
          if (bit_idx_q == 3'd7) state_d = PARITY;
`else
          if (bit_idx_q == 3'd7) state_d = STOP;
`endif
          else                   state_d = DATA;
        end else begin
          state_d = DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
        else         state_d = PARITY;
      end
`endif
      STOP: begin
        if (bit_end && have_data) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_dout;
          state_d  = START;
        end else if (bit_end) begin
          state_d = IDLE;
        end else begin
          state_d = STOP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef UART_TX_PARITY_EN
  // Parity is captured together with the byte it protects.
  always_comb begin
    if (fifo_pop) parity_d = even_parity(fifo_dout);
    else          parity_d = parity_q;
  end
`endif

  // tx mirrors the current state one cycle later so it leaves a flop directly.
  always_comb begin
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // An overflowing write wins over a simultaneous clear.
  always_comb begin
    if (wr_en && fifo_full) ovf_d = 1'b1;
    else if (ovf_clr)       ovf_d = 1'b0;
    else                    ovf_d = ovf_q;
  end

  // Status byte for the read-side mux.
  always_comb begin
    status            = 8'h00;
    status[OVF_BIT]   = ovf_q;
    status[BUSY_BIT]  = (state_q != IDLE);
    status[FULL_BIT]  = fifo_full;
    status[EMPTY_BIT] = fifo_empty;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      baud_q    <= 16'd0;
      bit_idx_q <= 3'd0;
      shreg_q   <= {UART_DATA_BITS{1'b0}};
      tx_q      <= 1'b1;
      ovf_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
      ovf_q     <= ovf_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// Self-checking bench for uart_tx_port (BAUD_DIV=4, FIFO_DEPTH=4); frames are
// decoded from the tx line and compared against an expected-frame model.
module tb_uart_tx_port;

  localparam int BD    = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int S_OVF = 3, S_BUSY = 2, S_FULL = 1, S_EMPTY = 0;

  logic       clk = 1'b0, reset = 1'b1, wr_en = 1'b0, ovf_clr = 1'b0;
  logic [7:0] din = 8'h00;
  logic       tx;
  logic [7:0] status;
  int         cyc = 0;
  int         n_pass = 0, n_total = 0;
  logic [10:0] rx_bits_q[$];
  int          rx_start_q[$];

  uart_tx_port #(.BAUD_DIV(BD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .din(din),
    .ovf_clr(ovf_clr), .tx(tx), .status(status)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected line levels of one frame: start, data LSB first, [parity], stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    f = 11'h7FF;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = ((b >> i) & 8'd1) != 8'd0;
      ones += int'((b >> i) & 8'd1);
    end
`ifdef UART_TX_PARITY_EN
    f[9] = (ones % 2) == 1;
`endif
    return f;
  endfunction

  // Line decoder: samples each bit mid-period, drops frames cut by reset.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && tx === 1'b0) begin
        logic [10:0] bits;
        int st;
        bit ab;
        bits = 11'h7FF;
        st = cyc;
        ab = 1'b0;
        for (int s = 1; s < NB*BD; s++) begin
          @(negedge clk);
          if (reset !== 1'b0) begin
            ab = 1'b1;
            break;
          end
          if (s % BD == BD/2) bits[s/BD] = tx;
        end
        if (!ab) begin
          rx_bits_q.push_back(bits);
          rx_start_q.push_back(st);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic write_byte(input logic [7:0] b, output int wc);
    din = b;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    wc = cyc;
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while (!(status[S_BUSY] === 1'b0 && status[S_EMPTY] === 1'b1) && k < bound) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_rx();
    rx_bits_q.delete();
    rx_start_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx);
    else n_pass++;
    n_total++;
    if (status !== 8'h01) $display("FAIL reset_status: got %h want 01", status);
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single(input logic [7:0] b, input string tag);
    int wc, first, nbusy;
    clear_rx();
    write_byte(b, wc);
    first = -1;
    nbusy = 0;
    for (int k = 0; k < 20*NB*BD; k++) begin
      @(negedge clk);
      if (status[S_BUSY] === 1'b1) begin
        nbusy++;
        if (first < 0) first = cyc;
      end else if (first >= 0) begin
        break;
      end
    end
    repeat (3) @(negedge clk);
    n_total++;
    if (first !== wc + 1) $display("FAIL %s_busy_start: got %0d want %0d", tag, first, wc + 1);
    else n_pass++;
    n_total++;
    if (nbusy !== NB*BD) $display("FAIL %s_busy_len: got %0d want %0d", tag, nbusy, NB*BD);
    else n_pass++;
    n_total++;
    if (rx_bits_q.size() !== 1) $display("FAIL %s_frames: got %0d want 1", tag, rx_bits_q.size());
    else n_pass++;
    if (rx_bits_q.size() >= 1) begin
      n_total++;
      if (rx_start_q[0] !== wc + 2) $display("FAIL %s_tx_low: got cycle %0d want %0d", tag, rx_start_q[0], wc + 2);
      else n_pass++;
      n_total++;
      if (rx_bits_q[0] !== frame_of(b)) $display("FAIL %s_bits: got %b want %b", tag, rx_bits_q[0], frame_of(b));
      else n_pass++;
    end
    n_total++;
    if (status !== 8'h01 || tx !== 1'b1) $display("FAIL %s_after: got status %h tx %b want 01 1", tag, status, tx);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int wc, first, nbusy;
    clear_rx();
    din = 8'h00;
    wr_en = 1'b1;
    @(negedge clk);
    wc = cyc;
    din = 8'hFF;
    @(negedge clk);
    wr_en = 1'b0;
    first = -1;
    nbusy = 1;
    for (int k = 0; k < 20*NB*BD; k++) begin
      @(negedge clk);
      if (status[S_BUSY] === 1'b1) nbusy++;
      else break;
    end
    repeat (3) @(negedge clk);
    n_total++;
    if (nbusy !== 2*NB*BD) $display("FAIL b2b_busy_len: got %0d want %0d", nbusy, 2*NB*BD);
    else n_pass++;
    n_total++;
    if (rx_bits_q.size() !== 2) $display("FAIL b2b_frames: got %0d want 2", rx_bits_q.size());
    else n_pass++;
    if (rx_bits_q.size() >= 2) begin
      n_total++;
      if (rx_bits_q[0] !== frame_of(8'h00) || rx_bits_q[1] !== frame_of(8'hFF))
        $display("FAIL b2b_bits: got %b %b want %b %b", rx_bits_q[0], rx_bits_q[1], frame_of(8'h00), frame_of(8'hFF));
      else n_pass++;
      n_total++;
      if (rx_start_q[1] - rx_start_q[0] !== NB*BD)
        $display("FAIL b2b_gap: got %0d want %0d", rx_start_q[1] - rx_start_q[0], NB*BD);
      else n_pass++;
      n_total++;
      if (rx_start_q[0] !== wc + 2) $display("FAIL b2b_first_start: got %0d want %0d", rx_start_q[0], wc + 2);
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    bit seen_full = 1'b0;
    int n_exp;
    clear_rx();
    wr_en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      din = 8'(i);
      @(negedge clk);
      if (status[S_FULL] === 1'b1) seen_full = 1'b1;
    end
    wr_en = 1'b0;
    n_total++;
    if (seen_full !== 1'b1) $display("FAIL ovf_full_seen: got %b want 1", seen_full);
    else n_pass++;
    n_total++;
    if (status[S_OVF] !== 1'b1) $display("FAIL ovf_set: got %b want 1", status[S_OVF]);
    else n_pass++;
    wait_idle(20*NB*BD);
    n_exp = (6 < DEPTH + 1) ? 6 : DEPTH + 1;
    n_total++;
    if (rx_bits_q.size() !== n_exp) $display("FAIL ovf_frames: got %0d want %0d", rx_bits_q.size(), n_exp);
    else n_pass++;
    for (int i = 0; i < rx_bits_q.size() && i < n_exp; i++) begin
      n_total++;
      if (rx_bits_q[i] !== frame_of(8'(i + 1))) $display("FAIL ovf_byte%0d: got %b want %b", i, rx_bits_q[i], frame_of(8'(i + 1)));
      else n_pass++;
    end
    n_total++;
    if (status !== 8'h09) $display("FAIL ovf_sticky: got %h want 09", status);
    else n_pass++;
  endtask

  task automatic test_ovf_clr();
    logic [7:0] sent[$];
    logic [7:0] b;
    clear_rx();
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    n_total++;
    if (status[S_OVF] !== 1'b0) $display("FAIL clr_lone1: got %b want 0", status[S_OVF]);
    else n_pass++;
    wr_en = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      b = 8'($urandom);
      sent.push_back(b);
      din = b;
      @(negedge clk);
    end
    din = 8'hEE;
    ovf_clr = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    ovf_clr = 1'b0;
    n_total++;
    if (status[S_OVF] !== 1'b1) $display("FAIL clr_with_ovf: got %b want 1", status[S_OVF]);
    else n_pass++;
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    n_total++;
    if (status[S_OVF] !== 1'b0) $display("FAIL clr_lone2: got %b want 0", status[S_OVF]);
    else n_pass++;
    wait_idle(20*NB*BD);
    n_total++;
    if (rx_bits_q.size() !== sent.size()) $display("FAIL clr_frames: got %0d want %0d", rx_bits_q.size(), sent.size());
    else n_pass++;
    for (int i = 0; i < rx_bits_q.size() && i < sent.size(); i++) begin
      n_total++;
      if (rx_bits_q[i] !== frame_of(sent[i])) $display("FAIL clr_byte%0d: got %b want %b", i, rx_bits_q[i], frame_of(sent[i]));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int wc;
    logic [7:0] b;
    clear_rx();
    write_byte(8'h3C, wc);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_total++;
    if (tx !== 1'b1 || status !== 8'h01) $display("FAIL midreset_state: got tx %b status %h want 1 01", tx, status);
    else n_pass++;
    reset = 1'b0;
    repeat (NB*BD + 5) @(negedge clk);
    n_total++;
    if (rx_bits_q.size() !== 0 || tx !== 1'b1) $display("FAIL midreset_abort: got frames %0d tx %b want 0 1", rx_bits_q.size(), tx);
    else n_pass++;
    b = 8'($urandom);
    write_byte(b, wc);
    wait_idle(4*NB*BD);
    n_total++;
    if (rx_bits_q.size() !== 1) $display("FAIL midreset_fresh_frames: got %0d want 1", rx_bits_q.size());
    else n_pass++;
    if (rx_bits_q.size() >= 1) begin
      n_total++;
      if (rx_bits_q[0] !== frame_of(b) || rx_start_q[0] !== wc + 2)
        $display("FAIL midreset_fresh: got %b @%0d want %b @%0d", rx_bits_q[0], rx_start_q[0], frame_of(b), wc + 2);
      else n_pass++;
    end
  endtask

  task automatic test_random_stream();
    logic [7:0] sent[$];
    logic [7:0] b;
    int wc, gap, guard;
    clear_rx();
    for (int i = 0; i < 10; i++) begin
      gap = $urandom_range(0, 2*NB*BD);
      repeat (gap) @(negedge clk);
      guard = 0;
      while (status[S_FULL] === 1'b1 && guard < 20*NB*BD) begin
        @(negedge clk);
        guard++;
      end
      b = 8'($urandom);
      sent.push_back(b);
      write_byte(b, wc);
    end
    wait_idle(40*NB*BD);
    n_total++;
    if (rx_bits_q.size() !== sent.size()) $display("FAIL rand_frames: got %0d want %0d", rx_bits_q.size(), sent.size());
    else n_pass++;
    for (int i = 0; i < rx_bits_q.size() && i < sent.size(); i++) begin
      n_total++;
      if (rx_bits_q[i] !== frame_of(sent[i])) $display("FAIL rand_byte%0d: got %b want %b", i, rx_bits_q[i], frame_of(sent[i]));
      else n_pass++;
    end
    n_total++;
    if (status !== 8'h01) $display("FAIL rand_status: got %h want 01", status);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single(8'hA5, "a5");
    test_single(8'($urandom), "rand_single");
    test_back_to_back();
    test_overflow();
    test_ovf_clr();
    test_reset_mid();
    test_random_stream();
`ifdef UART_TX_PARITY_EN
    test_single(8'h07, "parity07");
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
